// File: rtl/float_to_int_rm.sv
// float_to_int_rm: multi-cycle binary32 -> integer converter with selectable
// rounding mode, signed/unsigned result and invalid/inexact flags.
// An iterative shifter aligns the significand SHIFT_STEP bits per cycle.
module float_to_int_rm #(
    parameter int INT_WIDTH  = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [31:0]          a_value_i,
    input  logic                 signed_i,
    input  logic [1:0]           round_mode_i,
    input  logic                 exec_strobe_i,
    output logic [INT_WIDTH-1:0] z_value_o,
    output logic                 invalid_o,
    output logic                 inexact_o,
    output logic                 busy_o,
    output logic                 done_strobe_o
);

    // Working magnitude is wide enough for the 24-bit significand and for
    // W+1 bits, so a rounding carry out of bit W-1 is never lost.
    localparam int MW = (INT_WIDTH + 1 > 24) ? INT_WIDTH + 1 : 24;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_UNPACK  = 3'd1;
    localparam logic [2:0] S_SPECIAL = 3'd2;
    localparam logic [2:0] S_ALIGN   = 3'd3;
    localparam logic [2:0] S_ROUND   = 3'd4;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam logic [MW-1:0] ONE_M    = MW'(1'b1);
    localparam logic [MW-1:0] SMAX_M   = (ONE_M << (INT_WIDTH - 1)) - ONE_M;
    localparam logic [MW-1:0] SMIN_M   = ONE_M << (INT_WIDTH - 1);
    localparam logic [MW-1:0] UMAX_M   = (ONE_M << INT_WIDTH) - ONE_M;
    localparam logic [INT_WIDTH-1:0] Z_SMAX = SMAX_M[INT_WIDTH-1:0];
    localparam logic [INT_WIDTH-1:0] Z_SMIN = SMIN_M[INT_WIDTH-1:0];
    localparam logic [INT_WIDTH-1:0] Z_UMAX = {INT_WIDTH{1'b1}};
    localparam logic [INT_WIDTH-1:0] Z_ZERO = {INT_WIDTH{1'b0}};
    // Biased exponent at which e reaches INT_WIDTH (always saturates).
    localparam logic [7:0] EXP_SAT = 8'(127 + INT_WIDTH);

    logic [2:0]           state_r, state_n;
    logic [31:0]          a_r, a_n;
    logic                 sgn_mode_r, sgn_mode_n;
    logic [1:0]           rm_r, rm_n;
    logic                 sign_r, sign_n;
    logic [7:0]           exp_r, exp_n;
    logic [23:0]          man_r, man_n;
    logic [MW-1:0]        mag_r, mag_n;
    logic                 g_r, g_n;
    logic                 st_r, st_n;
    logic [6:0]           cnt_r, cnt_n;
    logic                 left_r, left_n;
    logic [INT_WIDTH-1:0] z_r, z_n;
    logic                 inv_r, inv_n;
    logic                 inx_r, inx_n;
    logic                 done_r, done_n;
    logic                 busy_r, busy_n;

    logic [6:0]           sh_amt_s;
    logic [MW-1:0]        sh_mag_s;
    logic                 sh_g_s;
    logic                 sh_st_s;
    logic                 inc_s;
    logic [MW-1:0]        rmag_s;
    logic [INT_WIDTH-1:0] sat_hi_s;
    logic [INT_WIDTH-1:0] sat_lo_s;

    // One ALIGN step: shift up to SHIFT_STEP bits, collecting guard/sticky on right shifts.
    always_comb begin
        sh_amt_s = (cnt_r > 7'(SHIFT_STEP)) ? 7'(SHIFT_STEP) : cnt_r;
        sh_mag_s = mag_r;
        sh_g_s   = g_r;
        sh_st_s  = st_r;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (7'(i) < sh_amt_s) begin
                if (left_r) begin
                    sh_mag_s = sh_mag_s << 1;
                end else begin
                    sh_st_s  = sh_st_s | sh_g_s;
                    sh_g_s   = sh_mag_s[0];
                    sh_mag_s = sh_mag_s >> 1;
                end
            end else begin
                sh_mag_s = sh_mag_s;
            end
        end
    end

    // Rounding increment decision and saturation values for the captured mode.
    always_comb begin
        case (rm_r)
            RM_RNE:  inc_s = g_r & (st_r | mag_r[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RDN:  inc_s = sign_r & (g_r | st_r);
            RM_RUP:  inc_s = ~sign_r & (g_r | st_r);
            default: inc_s = 1'b0;
        endcase
        rmag_s   = mag_r + {{(MW-1){1'b0}}, inc_s};
        sat_hi_s = sgn_mode_r ? Z_SMAX : Z_UMAX;
        sat_lo_s = sgn_mode_r ? Z_SMIN : Z_ZERO;
    end

    // Next-state and datapath update for the conversion sequence.
    always_comb begin
        state_n    = state_r;
        a_n        = a_r;
        sgn_mode_n = sgn_mode_r;
        rm_n       = rm_r;
        sign_n     = sign_r;
        exp_n      = exp_r;
        man_n      = man_r;
        mag_n      = mag_r;
        g_n        = g_r;
        st_n       = st_r;
        cnt_n      = cnt_r;
        left_n     = left_r;
        z_n        = z_r;
        inv_n      = inv_r;
        inx_n      = inx_r;
        done_n     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (exec_strobe_i) begin
                    a_n        = a_value_i;
                    sgn_mode_n = signed_i;
                    rm_n       = round_mode_i;
                    state_n    = S_UNPACK;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_UNPACK: begin
                // e = exp - 127 is handled implicitly through biased compares.
                sign_n  = a_r[31];
                exp_n   = a_r[30:23];
                man_n   = {1'b1, a_r[22:0]};
                state_n = S_SPECIAL;
            end
            S_SPECIAL: begin
                if (exp_r == 8'hFF) begin
                    z_n     = (man_r[22:0] != 23'd0) ? sat_hi_s : (sign_r ? sat_lo_s : sat_hi_s);
                    inv_n   = 1'b1;
                    inx_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (exp_r == 8'h00) begin
                    if (man_r[22:0] == 23'd0) begin
                        z_n     = Z_ZERO;
                        inv_n   = 1'b0;
                        inx_n   = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        // Denormals are far below 1: only sticky survives.
                        mag_n   = {MW{1'b0}};
                        g_n     = 1'b0;
                        st_n    = 1'b1;
                        cnt_n   = 7'd0;
                        left_n  = 1'b0;
                        state_n = S_ALIGN;
                    end
                end else if (exp_r >= EXP_SAT) begin
                    z_n     = sign_r ? sat_lo_s : sat_hi_s;
                    inv_n   = 1'b1;
                    inx_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    mag_n   = MW'(man_r);
                    g_n     = 1'b0;
                    st_n    = 1'b0;
                    state_n = S_ALIGN;
                    if (exp_r >= 8'd150) begin
                        left_n = 1'b1;
                        cnt_n  = 7'(exp_r - 8'd150);
                    end else begin
                        left_n = 1'b0;
                        cnt_n  = (exp_r <= 8'd125) ? 7'd25 : 7'(8'd150 - exp_r);
                    end
                end
            end
            S_ALIGN: begin
                mag_n   = sh_mag_s;
                g_n     = sh_g_s;
                st_n    = sh_st_s;
                cnt_n   = cnt_r - sh_amt_s;
                state_n = (cnt_r <= 7'(SHIFT_STEP)) ? S_ROUND : S_ALIGN;
            end
            S_ROUND: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
                inx_n   = g_r | st_r;
                inv_n   = 1'b0;
                if (sgn_mode_r && !sign_r && (rmag_s > SMAX_M)) begin
                    z_n   = Z_SMAX;
                    inv_n = 1'b1;
                    inx_n = 1'b0;
                end else if (sgn_mode_r && sign_r && (rmag_s > SMIN_M)) begin
                    z_n   = Z_SMIN;
                    inv_n = 1'b1;
                    inx_n = 1'b0;
                end else if (!sgn_mode_r && sign_r) begin
                    z_n = Z_ZERO;
                    if (rmag_s != {MW{1'b0}}) begin
                        inv_n = 1'b1;
                        inx_n = 1'b0;
                    end else begin
                        inv_n = 1'b0;
                    end
                end else if (!sgn_mode_r && (rmag_s > UMAX_M)) begin
                    z_n   = Z_UMAX;
                    inv_n = 1'b1;
                    inx_n = 1'b0;
                end else begin
                    z_n = sign_r ? (~rmag_s[INT_WIDTH-1:0] + INT_WIDTH'(1'b1))
                                 : rmag_s[INT_WIDTH-1:0];
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r    <= S_IDLE;
            a_r        <= 32'd0;
            sgn_mode_r <= 1'b0;
            rm_r       <= 2'b00;
            sign_r     <= 1'b0;
            exp_r      <= 8'd0;
            man_r      <= 24'd0;
            mag_r      <= {MW{1'b0}};
            g_r        <= 1'b0;
            st_r       <= 1'b0;
            cnt_r      <= 7'd0;
            left_r     <= 1'b0;
            z_r        <= Z_ZERO;
            inv_r      <= 1'b0;
            inx_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            a_r        <= a_n;
            sgn_mode_r <= sgn_mode_n;
            rm_r       <= rm_n;
            sign_r     <= sign_n;
            exp_r      <= exp_n;
            man_r      <= man_n;
            mag_r      <= mag_n;
            g_r        <= g_n;
            st_r       <= st_n;
            cnt_r      <= cnt_n;
            left_r     <= left_n;
            z_r        <= z_n;
            inv_r      <= inv_n;
            inx_r      <= inx_n;
            done_r     <= done_n;
            busy_r     <= busy_n;
        end
    end

    assign z_value_o     = z_r;
    assign invalid_o     = inv_r;
    assign inexact_o     = inx_r;
    assign done_strobe_o = done_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_float_to_int_rm.sv
// Directed testbench for float_to_int_rm (W=32, SHIFT_STEP=1 plus a
// SHIFT_STEP=4 instance sharing the same inputs).
module tb_float_to_int_rm;

    logic        clk;
    logic        reset_i;
    logic [31:0] a_value_i;
    logic        signed_i;
    logic [1:0]  round_mode_i;
    logic        exec_strobe_i;
    logic [31:0] z;
    logic        inv;
    logic        inx;
    logic        busy;
    logic        done;
    logic [31:0] z4;
    logic        inv4;
    logic        inx4;
    logic        busy4;
    logic        done4;

    int total = 0;
    int bad   = 0;
    int edges;
    int first4;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;

    float_to_int_rm #(.INT_WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset_i(reset_i), .a_value_i(a_value_i), .signed_i(signed_i),
        .round_mode_i(round_mode_i), .exec_strobe_i(exec_strobe_i),
        .z_value_o(z), .invalid_o(inv), .inexact_o(inx), .busy_o(busy),
        .done_strobe_o(done)
    );

    float_to_int_rm #(.INT_WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset_i(reset_i), .a_value_i(a_value_i), .signed_i(signed_i),
        .round_mode_i(round_mode_i), .exec_strobe_i(exec_strobe_i),
        .z_value_o(z4), .invalid_o(inv4), .inexact_o(inx4), .busy_o(busy4),
        .done_strobe_o(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands with the strobe; returns #1 after the accepting edge.
    task automatic start(input logic [31:0] a, input logic sg, input logic [1:0] rm);
        a_value_i     = a;
        signed_i      = sg;
        round_mode_i  = rm;
        exec_strobe_i = 1'b1;
        first4        = -1;
        @(posedge clk);
        #1;
        exec_strobe_i = 1'b0;
    endtask

    // Count edges after edge 0 until done is seen (bounded).
    task automatic wait_done(input int e0);
        edges = e0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (done4 && first4 < 0) first4 = edges;
            if (done || edges >= 200) break;
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] ez, input logic ei,
                             input logic ex, input int ee);
        chk({tag, ".z"}, 64'(z), 64'(ez));
        chk({tag, ".inv"}, 64'(inv), 64'(ei));
        chk({tag, ".inx"}, 64'(inx), 64'(ex));
        chk({tag, ".edge"}, 64'(edges), 64'(ee));
    endtask

    task automatic conv(input string tag, input logic [31:0] a, input logic sg,
                        input logic [1:0] rm, input logic [31:0] ez, input logic ei,
                        input logic ex, input int ee);
        start(a, sg, rm);
        wait_done(0);
        check_res(tag, ez, ei, ex, ee);
    endtask

    initial begin
        reset_i       = 1'b1;
        a_value_i     = 32'd0;
        signed_i      = 1'b0;
        round_mode_i  = 2'b00;
        exec_strobe_i = 1'b0;
        first4        = -1;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("rst.z", 64'(z), 64'd0);
        chk("rst.inv", 64'(inv), 64'd0);
        chk("rst.inx", 64'(inx), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);

        // pi, signed RNE; step-4 instance finishes on edge 9
        start(32'h40490FDB, 1'b1, RNE);
        chk("pi.busy", 64'(busy), 64'd1);
        wait_done(0);
        check_res("pi", 32'd3, 1'b0, 1'b1, 25);
        chk("pi4.edge", 64'(first4), 64'd9);
        chk("pi4.z", 64'(z4), 64'd3);
        chk("pi.busy_end", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("pi.done_1cyc", 64'(done), 64'd0);
        chk("pi.hold_z", 64'(z), 64'd3);

        conv("2p5rne", 32'h40200000, 1'b1, RNE, 32'd2, 1'b0, 1'b1, 25);
        conv("2p5rup", 32'h40200000, 1'b1, RUP, 32'd3, 1'b0, 1'b1, 25);
        conv("m2p5rdn", 32'hC0200000, 1'b1, RDN, 32'hFFFFFFFD, 1'b0, 1'b1, 25);
        conv("m2p5rtz", 32'hC0200000, 1'b1, RTZ, 32'hFFFFFFFE, 1'b0, 1'b1, 25);
        conv("1p5rne", 32'h3FC00000, 1'b1, RNE, 32'd2, 1'b0, 1'b1, 26);

        conv("p31s", 32'h4F000000, 1'b1, RNE, 32'h7FFFFFFF, 1'b1, 1'b0, 11);
        conv("p31u", 32'h4F000000, 1'b0, RNE, 32'h80000000, 1'b0, 1'b0, 11);
        conv("m31s", 32'hCF000000, 1'b1, RNE, 32'h80000000, 1'b0, 1'b0, 11);
        conv("big_s", 32'h501502F9, 1'b1, RNE, 32'h7FFFFFFF, 1'b1, 1'b0, 2);

        conv("nan_s", 32'h7FC00000, 1'b1, RNE, 32'h7FFFFFFF, 1'b1, 1'b0, 2);
        conv("minf_u", 32'hFF800000, 1'b0, RNE, 32'd0, 1'b1, 1'b0, 2);
        conv("mzero", 32'h80000000, 1'b1, RNE, 32'd0, 1'b0, 1'b0, 2);

        conv("m0p3rtz", 32'hBE99999A, 1'b0, RTZ, 32'd0, 1'b0, 1'b1, 28);
        conv("m0p3rdn", 32'hBE99999A, 1'b0, RDN, 32'd0, 1'b1, 1'b0, 28);
        conv("denrup", 32'h00000001, 1'b1, RUP, 32'd1, 1'b0, 1'b1, 4);

        // reset during ALIGN: outputs cleared, no done pulse afterwards
        start(32'h40490FDB, 1'b1, RNE);
        repeat (5) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("midrst.z", 64'(z), 64'd0);
        chk("midrst.inx", 64'(inx), 64'd0);
        chk("midrst.busy", 64'(busy), 64'd0);
        edges = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) edges++;
        end
        chk("midrst.no_done", 64'(edges), 64'd0);

        // reset wins over a simultaneous strobe
        a_value_i     = 32'h40200000;
        exec_strobe_i = 1'b1;
        reset_i       = 1'b1;
        @(posedge clk);
        #1;
        exec_strobe_i = 1'b0;
        reset_i       = 1'b0;
        chk("rst_vs_strobe.busy", 64'(busy), 64'd0);

        // strobe while busy is ignored
        start(32'h40200000, 1'b1, RNE);
        repeat (4) @(posedge clk);
        #1;
        a_value_i     = 32'h7FC00000;
        exec_strobe_i = 1'b1;
        @(posedge clk);
        #1;
        exec_strobe_i = 1'b0;
        wait_done(5);
        check_res("busy_strobe", 32'd2, 1'b0, 1'b1, 25);

        // back-to-back: strobe during the done cycle
        start(32'h40200000, 1'b1, RUP);
        wait_done(0);
        check_res("b2b_first", 32'd3, 1'b0, 1'b1, 25);
        start(32'h3FC00000, 1'b1, RNE);
        chk("b2b.busy", 64'(busy), 64'd1);
        wait_done(0);
        check_res("b2b_second", 32'd2, 1'b0, 1'b1, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_to_int_rm.md
# float_to_int_rm

Multi-cycle IEEE-754 single-precision to integer converter for the FPU. It generalises the existing conversion with three additions: a parametrised result width, a signed/unsigned mode, and four selectable rounding modes. It also reports invalid and inexact exception flags. It uses the FPU's exec/done strobe handshake and an iterative alignment shifter, with a configurable number of shift bits per cycle.

## Interface
- `INT_WIDTH`, default 32: integer result width; legal range 8..64.
- `SHIFT_STEP`, default 1: bits shifted per ALIGN cycle; legal values 1, 2, 4, 8.
- `clk`, in, 1: clock. Single clock domain.
- `reset_i`, in, 1: synchronous, active-high reset.
- `a_value_i`, in, 32: binary32 operand.
- `signed_i`, in, 1: 1 = signed result, 0 = unsigned result.
- `round_mode_i`, in, 2: 00 RNE (nearest-even), 01 RTZ (toward zero), 10 RDN (toward −inf), 11 RUP (toward +inf).
- `exec_strobe_i`, in, 1: start request. Accepted only in IDLE.
- `z_value_o`, out, `INT_WIDTH`: result. Two's complement when signed.
- `invalid_o`, out, 1: NaN, infinity or out-of-range result.
- `inexact_o`, out, 1: result differs from the operand. Forced to 0 when `invalid_o` = 1.
- `busy_o`, out, 1: high whenever the state is not IDLE.
- `done_strobe_o`, out, 1: one-cycle pulse marking that results have been updated.

## Operation
- **States:** IDLE → UNPACK → SPECIAL → ALIGN → ROUND → IDLE. SPECIAL can return directly to IDLE.
- **IDLE:** when `exec_strobe_i` = 1, capture `a_value_i`, `signed_i` and `round_mode_i` on the same edge. Inputs are never re-read afterwards. Strobes seen outside IDLE are ignored.
- **UNPACK:** s = bit 31; E = bits 30:23; e = E − 127 (signed, 9 bits); m = {1, frac}, 24 bits.
- **SPECIAL:** exits to IDLE on these cases:
  - NaN: result max, invalid.
  - ±inf: result max or min by sign, invalid.
  - ±0: result 0, no flags.
  - Normal with e ≥ `INT_WIDTH`: saturate by sign, invalid.
  - Saturation values: max = 2^(W−1)−1 signed, 2^W−1 unsigned. min = −2^(W−1) signed, 0 unsigned.
  - Any negative operand that reaches the unsigned saturation path returns 0 with invalid set.
  - Nonzero denormal: mag = 0, guard g = 0, sticky st = 1. Go to ALIGN for exactly one cycle.
  - Otherwise go to ALIGN.
- **ALIGN:** holds a (W+1)-bit magnitude plus g and st.
  - e ≥ 23: shift left by n = e − 23.
  - e < 23: shift right by n = min(23 − e, 25). Bits shifted out feed g (last bit out) and st (OR of all earlier bits out).
  - Shift by up to `SHIFT_STEP` bits per cycle. ALIGN lasts max(k, 1) cycles, where k = ceil(n / `SHIFT_STEP`).
- **ROUND:** increment the magnitude when:
  - RNE: g & (st | lsb).
  - RTZ: never.
  - RDN: s & (g | st).
  - RUP: !s & (g | st).
  - Inexact = g | st.
- **Range check, after rounding:**
  - Signed: positive mag > 2^(W−1)−1 → max, invalid. Negative mag > 2^(W−1) → min, invalid.
  - Unsigned: negative with rounded mag ≠ 0 → 0, invalid. Negative with rounded mag = 0 → 0, inexact as computed. Positive mag > 2^W−1 → max, invalid.
  - Otherwise z = s ? −mag : mag.
- `z_value_o`, `invalid_o` and `inexact_o` hold their values until the next completion.

## Timing
- Edge 0 is the edge that samples `exec_strobe_i` in IDLE. `busy_o` goes high after edge 0.
- Outputs, flags and `done_strobe_o` = 1 are all written on the edge that returns the FSM to IDLE. `busy_o` drops on that same edge.
- Special-case exit: edge 2.
- Normal and denormal exit: edge 3 + max(k, 1).
- `done_strobe_o` is high for exactly one cycle. A strobe in that cycle is accepted, giving back-to-back operation.
- **Reset:** state IDLE; `z_value_o` = 0; `invalid_o`, `inexact_o`, `busy_o` and `done_strobe_o` = 0. Reset mid-operation aborts with no done pulse. Reset wins over a simultaneous strobe.

## Test plan
Parameters W = 32, `SHIFT_STEP` = 1 unless stated.
- 0x40490FDB (π), signed, RNE → z = 3, inexact = 1, invalid = 0. n = 22, so `done_strobe_o` rises on edge 25. Repeat with `SHIFT_STEP` = 4 → edge 9.
- 0x40200000 (2.5): RNE → 2, RUP → 3. 0xC0200000 (−2.5): RDN → 0xFFFFFFFD, RTZ → 0xFFFFFFFE. 0x3FC00000 (1.5), RNE → 2. All inexact.
- 0x4F000000 (2^31): signed → 0x7FFFFFFF, invalid; unsigned → 0x80000000, exact. 0xCF000000 (−2^31) signed → 0x80000000, no flags.
- 0x7FC00000 signed → 0x7FFFFFFF, invalid, done on edge 2. 0xFF800000 unsigned → 0, invalid. 0x80000000 → 0, no flags.
- 0xBE99999A (−0.3), unsigned: RTZ → 0 with inexact only; RDN → 0 with invalid. 0x00000001 RUP → 1, inexact.
- Reset asserted during ALIGN → no done pulse, outputs cleared. A strobe while `busy_o` = 1 is ignored. A strobe in the done cycle starts a new conversion.
